// File: rtl/vs10xx_spi_responder_if.sv
// Pin-level bus between an mp3 player SPI master and the VS10xx responder.
//   i_SCK   SPI clock from master          i_SI   SPI data, MSB first
//   i_XCS   SCI select, active low         i_XDCS SDI select, active low
//   i_XRST  decoder hard reset, active low
//   o_SO    SCI read data to master        o_DREQ data request to master
// Modports: master (player side), slave (decoder side).
interface vs10xx_spi_responder_if;
  logic i_SCK;
  logic i_SI;
  logic i_XCS;
  logic i_XDCS;
  logic i_XRST;
  logic o_SO;
  logic o_DREQ;

  modport master (
    output i_SCK, i_SI, i_XCS, i_XDCS, i_XRST,
    input  o_SO, o_DREQ
  );

  modport slave (
    input  i_SCK, i_SI, i_XCS, i_XDCS, i_XRST,
    output o_SO, o_DREQ
  );
endinterface

// File: rtl/vs10xx_spi_responder.sv
// VS10xx decoder SPI-side responder model.
// Receives XCS-framed SCI commands into a 16x16 register file and
// XDCS-framed SDI audio bytes into a FIFO that is drained at a fixed
// decode rate; drives DREQ from boot state and free FIFO space.
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   spi              SPI pins (slave modport): SCK/SI/XCS/XDCS/XRST in, SO/DREQ out
//   o_vol, o_mode    SCI_VOL (0x0B) and SCI_MODE (0x00) contents
//   o_byte           byte popped from the FIFO, qualified by o_byte_valid
//   o_fifo_level     FIFO occupancy
//   o_overflow       sticky: byte arrived while FIFO was full
//   o_bad_cmd        one-clk strobe: bad opcode/address, short frame, select conflict
// Build option: define VS_RESP_SCI_READ_EN to accept opcode 0x03 (SCI read)
// and serialize the addressed register on SO; otherwise 0x03 is a bad opcode
// and SO is tied low.
module vs10xx_spi_responder #(
  parameter int FIFO_DEPTH  = 64,
  parameter int DREQ_THRESH = 32,
  parameter int DRAIN_DIV   = 200,
  parameter int BOOT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  vs10xx_spi_responder_if.slave         spi,
  output logic [15:0]                   o_vol,
  output logic [15:0]                   o_mode,
  output logic [7:0]                    o_byte,
  output logic                          o_byte_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  output logic                          o_bad_cmd
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int DIV_W  = $clog2(DRAIN_DIV + 1);
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SCI_SHIFT, SDI_SHIFT, CONFLICT} state_t;

  // Input synchronizers
  logic [2:0] sck_sync;
  logic [1:0] si_sync, xcs_sync, xdcs_sync, xrst_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      si_sync   <= '0;
      xcs_sync  <= 2'b11;
      xdcs_sync <= 2'b11;
      xrst_sync <= 2'b11;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi.i_SCK};
      si_sync   <= {si_sync[0], spi.i_SI};
      xcs_sync  <= {xcs_sync[0], spi.i_XCS};
      xdcs_sync <= {xdcs_sync[0], spi.i_XDCS};
      xrst_sync <= {xrst_sync[0], spi.i_XRST};
    end
  end

  logic sck_rise, si_s, xcs_s, xdcs_s, hard_rst;
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign si_s     = si_sync[1];
  assign xcs_s    = xcs_sync[1];
  assign xdcs_s   = xdcs_sync[1];
  // XRST pin acts exactly like rst_n, for as long as it is held low.
  assign hard_rst = ~rst_n | ~xrst_sync[1];

  state_t      state, state_next;
  logic [5:0]  bit_cnt;
  logic        sci_done;
  logic [31:0] sci_sr;
  logic [2:0]  byte_cnt;
  logic [7:0]  byte_sr;
  logic        push_req;
  logic [15:0] regs [16];

  logic bad_next, commit, wr_en, soft_rst, op_ok;

  // FSM next state and command decode
  always_comb begin
    state_next = state;
    bad_next   = 1'b0;
    commit     = (state == SCI_SHIFT) && (bit_cnt == 6'd32) && !sci_done;
`ifdef VS_RESP_SCI_READ_EN
    op_ok      = (sci_sr[31:24] == 8'h02) || (sci_sr[31:24] == 8'h03);
`else
    op_ok      = (sci_sr[31:24] == 8'h02);
`endif
    wr_en      = commit && (sci_sr[31:24] == 8'h02) && (sci_sr[23:20] == 4'h0);
    soft_rst   = wr_en && (sci_sr[19:16] == 4'h0) && sci_sr[2];
    if (commit && (!op_ok || sci_sr[23:20] != 4'h0)) bad_next = 1'b1;
    case (state)
      IDLE: begin
        if (!xcs_s && !xdcs_s) begin
          state_next = CONFLICT;
          bad_next   = 1'b1;
        end else if (!xcs_s) begin
          state_next = SCI_SHIFT;
        end else if (!xdcs_s) begin
          state_next = SDI_SHIFT;
        end
      end
      SCI_SHIFT: begin
        if (xcs_s) begin
          state_next = IDLE;
          if (bit_cnt != 6'd32) bad_next = 1'b1;
        end else if (!xdcs_s) begin
          state_next = CONFLICT;
          bad_next   = 1'b1;
        end
      end
      SDI_SHIFT: begin
        if (xdcs_s) begin
          state_next = IDLE;
        end else if (!xcs_s) begin
          state_next = CONFLICT;
          bad_next   = 1'b1;
        end
      end
      CONFLICT: begin
        if (xcs_s || xdcs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state     <= IDLE;
      o_bad_cmd <= 1'b0;
    end else begin
      state     <= state_next;
      o_bad_cmd <= bad_next;
    end
  end

  // Bit counters: cleared whenever the FSM is not in the matching shift state,
  // so partial frames/bytes are dropped on deselect.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      bit_cnt  <= '0;
      sci_done <= 1'b0;
      byte_cnt <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (state != SCI_SHIFT) begin
        bit_cnt  <= '0;
        sci_done <= 1'b0;
      end else begin
        if (sck_rise && bit_cnt != 6'd32) bit_cnt <= bit_cnt + 6'd1;
        if (commit) sci_done <= 1'b1;
      end
      if (state != SDI_SHIFT) begin
        byte_cnt <= '0;
      end else if (sck_rise) begin
        byte_cnt <= byte_cnt + 3'd1;
        if (byte_cnt == 3'd7) push_req <= 1'b1;
      end
    end
  end

  // Shift registers (data, no reset)
  always_ff @(posedge clk) begin
    if (state == SCI_SHIFT && sck_rise && bit_cnt != 6'd32) sci_sr <= {sci_sr[30:0], si_s};
    if (state == SDI_SHIFT && sck_rise) byte_sr <= {byte_sr[6:0], si_s};
  end

  // Register file; SM_RESET (MODE bit 2) is self-clearing.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= (i == 0) ? 16'h0800 : 16'h0000;
    end else if (wr_en) begin
      if (sci_sr[19:16] == 4'h0) regs[0] <= sci_sr[15:0] & ~16'h0004;
      else                        regs[sci_sr[19:16]] <= sci_sr[15:0];
    end
  end

  assign o_vol  = regs[11];
  assign o_mode = regs[0];

`ifdef VS_RESP_SCI_READ_EN
  logic        sck_fall, so_q, rd_active;
  logic [15:0] so_sr;
  assign sck_fall = ~sck_sync[1] & sck_sync[2];

  // SO changes on SCK fall so the master can sample it on the next rise.
  // The read is armed on the fall following the 16th rise, once opcode and
  // address are both in sci_sr[15:0].
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      so_q      <= 1'b0;
      so_sr     <= '0;
      rd_active <= 1'b0;
    end else if (state != SCI_SHIFT) begin
      so_q      <= 1'b0;
      rd_active <= 1'b0;
    end else if (sck_fall) begin
      if (bit_cnt == 6'd16 && sci_sr[15:8] == 8'h03 && sci_sr[7:4] == 4'h0) begin
        so_q      <= regs[sci_sr[3:0]][15];
        so_sr     <= {regs[sci_sr[3:0]][14:0], 1'b0};
        rd_active <= 1'b1;
      end else if (rd_active && bit_cnt > 6'd16 && bit_cnt < 6'd32) begin
        so_q  <= so_sr[15];
        so_sr <= {so_sr[14:0], 1'b0};
      end else begin
        so_q      <= 1'b0;
        rd_active <= 1'b0;
      end
    end
  end
  assign spi.o_SO = so_q;
`else
  assign spi.o_SO = 1'b0;
`endif

  // Audio FIFO and drain divider
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic [DIV_W-1:0] div_cnt;
  logic             div_tick, pop, push_ok;

  assign div_tick = (div_cnt == DIV_W'(DRAIN_DIV - 1));
  assign pop      = div_tick && (level != '0);
  // A pop in the same clk frees the slot, so a push into a full FIFO survives then.
  assign push_ok  = push_req && ((level != LW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (hard_rst || soft_rst) div_cnt <= '0;
    else if (div_tick)        div_cnt <= '0;
    else                      div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok && !hard_rst && !soft_rst) mem[wr_ptr] <= byte_sr;
  end

  always_ff @(posedge clk) begin
    if (hard_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      o_overflow   <= 1'b0;
      o_byte_valid <= 1'b0;
      o_byte       <= '0;
    end else if (soft_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      o_overflow   <= 1'b0;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= pop;
      if (pop) begin
        o_byte <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_req && !push_ok) o_overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign o_fifo_level = level;

  // Boot countdown and DREQ
  logic [BOOT_W-1:0] boot_cnt;
  logic [LW-1:0]     free_space;
  logic              dreq_q;
  assign free_space = LW'(FIFO_DEPTH) - level;

  always_ff @(posedge clk) begin
    if (hard_rst || soft_rst) begin
      boot_cnt <= BOOT_W'(BOOT_CYCLES);
      dreq_q   <= 1'b0;
    end else begin
      if (boot_cnt != '0) boot_cnt <= boot_cnt - BOOT_W'(1);
      dreq_q <= (boot_cnt == '0) && (free_space >= LW'(DREQ_THRESH));
    end
  end

  assign spi.o_DREQ = dreq_q;

endmodule

// File: tb/tb_vs10xx_spi_responder.sv
module tb_vs10xx_spi_responder;
  localparam int FD = 16;
  localparam int TH = 8;
  localparam int DD = 2000;
  localparam int BC = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vs10xx_spi_responder_if bus();
  logic [15:0]        vol, mode;
  logic [7:0]         byte_out;
  logic               byte_valid, overflow, bad_cmd;
  logic [$clog2(FD):0] level;

  vs10xx_spi_responder #(
    .FIFO_DEPTH(FD), .DREQ_THRESH(TH), .DRAIN_DIV(DD), .BOOT_CYCLES(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi(bus),
    .o_vol(vol), .o_mode(mode), .o_byte(byte_out), .o_byte_valid(byte_valid),
    .o_fifo_level(level), .o_overflow(overflow), .o_bad_cmd(bad_cmd)
  );

  int checks = 0;
  int passes = 0;
  int bad_cnt = 0;
  longint cyc = 0;
  logic [7:0] got_q[$];
  longint stamp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bad_cmd === 1'b1) bad_cnt++;
    if (byte_valid === 1'b1) begin
      got_q.push_back(byte_out);
      stamp_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] w, input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      bus.i_SI = w[n-1-i];
      clks(4);
      cap = {cap[30:0], bus.o_SO};
      bus.i_SCK = 1'b1;
      clks(4);
      bus.i_SCK = 1'b0;
    end
  endtask

  task automatic sdi_byte(input logic [7:0] b);
    logic [31:0] cap;
    spi_bits({24'h0, b}, 8, cap);
  endtask

  task automatic xrst_pulse();
    bus.i_XRST = 1'b0;
    clks(4);
    bus.i_XRST = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] vol;
    logic [15:0] mode;
    int          bad;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] cap;
    int b0;
    logic [15:0] exp_rd;
    int exp_rd_bad;

    vecs[0] = '{op: 8'h02, addr: 8'h0B, data: 16'h2020, vol: 16'h2020, mode: 16'h0800, bad: 0};
    vecs[1] = '{op: 8'h02, addr: 8'h00, data: 16'h0840, vol: 16'h2020, mode: 16'h0840, bad: 0};
    vecs[2] = '{op: 8'h05, addr: 8'h0B, data: 16'h1111, vol: 16'h2020, mode: 16'h0840, bad: 1};
    vecs[3] = '{op: 8'h02, addr: 8'h1B, data: 16'h3333, vol: 16'h2020, mode: 16'h0840, bad: 1};
    vecs[4] = '{op: 8'h02, addr: 8'h0B, data: 16'hFE01, vol: 16'hFE01, mode: 16'h0840, bad: 0};
    vecs[5] = '{op: 8'h02, addr: 8'h00, data: 16'h0800, vol: 16'hFE01, mode: 16'h0800, bad: 0};
    vecs[6] = '{op: 8'h02, addr: 8'h0B, data: 16'h2020, vol: 16'h2020, mode: 16'h0800, bad: 0};

    bus.i_SCK = 1'b0; bus.i_SI = 1'b0; bus.i_XCS = 1'b1; bus.i_XDCS = 1'b1; bus.i_XRST = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_so", bus.o_SO, 0);
    chk("rst_dreq", bus.o_DREQ, 0);
    chk("rst_vol", vol, 16'h0000);
    chk("rst_mode", mode, 16'h0800);
    chk("rst_byte", byte_out, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bad_cmd", bad_cmd, 0);
    rst_n = 1'b1;

    // Boot: DREQ rises on the (BC+1)-th clk after release
    clks(BC);
    chk("boot_dreq_low", bus.o_DREQ, 0);
    clks(1);
    chk("boot_dreq_high", bus.o_DREQ, 1);

    // SCI write vectors
    for (int i = 0; i < 7; i++) begin
      b0 = bad_cnt;
      bus.i_XCS = 1'b0;
      clks(4);
      spi_bits({vecs[i].op, vecs[i].addr, vecs[i].data}, 32, cap);
      clks(8);
      chk($sformatf("vec%0d_vol", i), vol, vecs[i].vol);
      chk($sformatf("vec%0d_mode", i), mode, vecs[i].mode);
      bus.i_XCS = 1'b1;
      clks(8);
      chk($sformatf("vec%0d_bad", i), bad_cnt - b0, vecs[i].bad);
    end

    // SCI read of VOL
`ifdef VS_RESP_SCI_READ_EN
    exp_rd = 16'h2020;
    exp_rd_bad = 0;
`else
    exp_rd = 16'h0000;
    exp_rd_bad = 1;
`endif
    b0 = bad_cnt;
    bus.i_XCS = 1'b0;
    clks(4);
    spi_bits(32'h030B_0000, 32, cap);
    chk("read_so_data", cap[15:0], exp_rd);
    chk("read_so_cmd_phase", cap[31:16], 0);
    clks(8);
    chk("read_so_after", bus.o_SO, 0);
    bus.i_XCS = 1'b1;
    clks(8);
    chk("read_bad", bad_cnt - b0, exp_rd_bad);
    chk("read_vol_kept", vol, 16'h2020);

    // Hard reset via XRST, then stream FD+1 bytes
    bus.i_XRST = 1'b0;
    clks(4);
    chk("xrst_vol", vol, 0);
    chk("xrst_mode", mode, 16'h0800);
    chk("xrst_dreq", bus.o_DREQ, 0);
    bus.i_XRST = 1'b1;
    got_q.delete();
    stamp_q.delete();
    bus.i_XDCS = 1'b0;
    clks(4);
    for (int i = 0; i < FD + 1; i++) begin
      sdi_byte((i < FD) ? 8'(i) : 8'hEE);
      clks(6);
      if (i == TH - 1) begin
        chk("stream_level_th", level, TH);
        chk("stream_dreq_at_th", bus.o_DREQ, 1);
      end
      if (i == TH) begin
        chk("stream_level_th1", level, TH + 1);
        chk("stream_dreq_above_th", bus.o_DREQ, 0);
      end
      if (i == FD - 1) begin
        chk("stream_level_full", level, FD);
        chk("stream_no_overflow", overflow, 0);
      end
    end
    chk("overflow_set", overflow, 1);
    chk("overflow_level", level, FD);
    bus.i_XDCS = 1'b1;
    clks(8);
    chk("no_early_pop", got_q.size(), 0);

    // Drain
    for (int k = 0; k < 40000 && got_q.size() < FD; k++) @(negedge clk);
    chk("drain_count", got_q.size(), FD);
    for (int i = 0; i < FD && i < got_q.size(); i++)
      chk($sformatf("drain_byte%0d", i), got_q[i], 8'(i));
    if (stamp_q.size() >= 3) begin
      chk("drain_interval0", 32'(stamp_q[1] - stamp_q[0]), DD);
      chk("drain_interval1", 32'(stamp_q[2] - stamp_q[1]), DD);
    end
    clks(2);
    chk("drain_level_zero", level, 0);
    chk("drain_dreq", bus.o_DREQ, 1);
    clks(DD + 10);
    chk("empty_no_strobe", got_q.size(), FD);

    // Partial SDI byte dropped; overflow sticky
    bus.i_XDCS = 1'b0;
    clks(4);
    spi_bits(32'h5, 3, cap);
    clks(4);
    bus.i_XDCS = 1'b1;
    clks(8);
    chk("partial_dropped", level, 0);
    chk("overflow_sticky", overflow, 1);

    xrst_pulse();
    clks(4);
    chk("xrst_clears_overflow", overflow, 0);

    // Short SCI frame
    b0 = bad_cnt;
    bus.i_XCS = 1'b0;
    clks(4);
    spi_bits(32'h020B_5555 >> 12, 20, cap);
    clks(8);
    bus.i_XCS = 1'b1;
    clks(8);
    chk("short_bad", bad_cnt - b0, 1);
    chk("short_vol_kept", vol, 0);

    // Both selects low
    b0 = bad_cnt;
    bus.i_XCS = 1'b0;
    bus.i_XDCS = 1'b0;
    clks(10);
    chk("conflict_bad", bad_cnt - b0, 1);
    spi_bits(32'hA5, 8, cap);
    clks(6);
    bus.i_XCS = 1'b1;
    clks(8);
    bus.i_XDCS = 1'b1;
    clks(8);
    chk("conflict_once", bad_cnt - b0, 1);
    chk("conflict_no_push", level, 0);

    // Soft reset through MODE bit 2
    bus.i_XDCS = 1'b0;
    clks(4);
    sdi_byte(8'hAA);
    sdi_byte(8'hBB);
    sdi_byte(8'hCC);
    clks(6);
    bus.i_XDCS = 1'b1;
    clks(8);
    chk("pre_soft_level", level, 3);
    b0 = bad_cnt;
    bus.i_XCS = 1'b0;
    clks(4);
    spi_bits(32'h0200_0804, 32, cap);
    clks(8);
    chk("soft_level", level, 0);
    chk("soft_mode", mode, 16'h0800);
    chk("soft_dreq", bus.o_DREQ, 0);
    bus.i_XCS = 1'b1;
    clks(8);
    chk("soft_no_bad", bad_cnt - b0, 0);
    clks(BC - 40);
    chk("soft_boot_low", bus.o_DREQ, 0);
    clks(60);
    chk("soft_boot_high", bus.o_DREQ, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
